// File: rtl/load_value_predictor.sv
// Last-value load predictor: direct-mapped table of (valid, tag, value, conf) indexed by load PC,
// one outstanding prediction at a time. Optional counters behind LOAD_VALUE_PREDICTOR_STATS_EN.
module load_value_predictor #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_BITS  = 6,
    parameter int CONF_BITS   = 2,
    parameter int CONF_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_pc,
    output logic                  req_ready,
    output logic                  pred_valid,
    output logic [DATA_WIDTH-1:0] pred_value,
    output logic                  busy,
    input  logic                  resolve_valid,
    input  logic [DATA_WIDTH-1:0] resolve_data,
    input  logic                  flush,
    output logic                  confirm,
    output logic                  mispredict
`ifdef LOAD_VALUE_PREDICTOR_STATS_EN
    ,
    output logic [31:0]           stat_pred,
    output logic [31:0]           stat_correct,
    output logic [31:0]           stat_mispred
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;
    localparam logic [CONF_BITS-1:0] CONF_MAX = '1;
    localparam logic [CONF_BITS-1:0] THRESH   = CONF_BITS'(CONF_THRESH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    function automatic logic [CONF_BITS-1:0] sat_inc(input logic [CONF_BITS-1:0] c);
        return (c == CONF_MAX) ? c : c + 1'b1;
    endfunction

    state_t state;

    logic                  tbl_valid [ENTRIES];
    logic [TAG_W-1:0]      tbl_tag   [ENTRIES];
    logic [DATA_WIDTH-1:0] tbl_value [ENTRIES];
    logic [CONF_BITS-1:0]  tbl_conf  [ENTRIES];

    logic [INDEX_BITS-1:0] req_idx_p0;
    logic [TAG_W-1:0]      req_tag_p0;
    logic                  hit_p0;
    logic                  pred_p0;
    logic                  req_fire;
    logic                  resolve_fire;
    logic                  data_match;
    logic                  unused_pc_bits;

    logic [INDEX_BITS-1:0] idx_p1;
    logic [TAG_W-1:0]      tag_p1;
    logic [DATA_WIDTH-1:0] value_p1;
    logic [CONF_BITS-1:0]  conf_p1;
    logic                  hit_p1;
    logic                  pred_p1;

    assign req_idx_p0     = req_pc[INDEX_BITS+1:2];
    assign req_tag_p0     = req_pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign unused_pc_bits = ^req_pc[1:0];

    assign hit_p0   = tbl_valid[req_idx_p0] && (tbl_tag[req_idx_p0] == req_tag_p0);
    assign pred_p0  = hit_p0 && (tbl_conf[req_idx_p0] >= THRESH);

    assign req_ready = (state == S_IDLE);
    assign busy      = (state == S_WAIT);
    assign req_fire  = req_valid && req_ready;

    // flush wins over resolve; a reset in the same cycle also suppresses training
    assign resolve_fire = (state == S_WAIT) && resolve_valid && !flush && !rst;
    assign data_match   = (resolve_data == value_p1);

    // Stage p0 -> p1: control, pulses and FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pred_valid <= 1'b0;
            pred_value <= '0;
            confirm    <= 1'b0;
            mispredict <= 1'b0;
            hit_p1     <= 1'b0;
            pred_p1    <= 1'b0;
        end else begin
            pred_valid <= 1'b0;
            pred_value <= '0;
            confirm    <= 1'b0;
            mispredict <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state      <= S_WAIT;
                        hit_p1     <= hit_p0;
                        pred_p1    <= pred_p0;
                        pred_valid <= pred_p0;
                        pred_value <= pred_p0 ? tbl_value[req_idx_p0] : '0;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (resolve_valid) begin
                        state      <= S_IDLE;
                        confirm    <= pred_p1 && data_match;
                        mispredict <= pred_p1 && !data_match;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage p0 -> p1: latched lookup address and entry snapshot
    always_ff @(posedge clk) begin
        if (req_fire) begin
            idx_p1   <= req_idx_p0;
            tag_p1   <= req_tag_p0;
            value_p1 <= tbl_value[req_idx_p0];
            conf_p1  <= tbl_conf[req_idx_p0];
        end
    end

    // Stage p1 -> table: training of valid/confidence
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_conf[i]  <= '0;
            end
        end else if (resolve_fire) begin
            if (hit_p1 && data_match) begin
                tbl_conf[idx_p1] <= sat_inc(conf_p1);
            end else begin
                tbl_valid[idx_p1] <= 1'b1;
                tbl_conf[idx_p1]  <= '0;
            end
        end
    end

    // Value/tag only change on a miss or a value change; a miss evicts any aliasing entry
    always_ff @(posedge clk) begin
        if (resolve_fire && !(hit_p1 && data_match)) begin
            tbl_value[idx_p1] <= resolve_data;
            tbl_tag[idx_p1]   <= tag_p1;
        end
    end

`ifdef LOAD_VALUE_PREDICTOR_STATS_EN
`ifdef SIMULATION
    function automatic void stats_event(input string name);
        $display("%m stats_event %s", name);
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pred    <= '0;
            stat_correct <= '0;
            stat_mispred <= '0;
        end else begin
            if (pred_valid) stat_pred    <= stat_pred + 32'd1;
            if (confirm)    stat_correct <= stat_correct + 32'd1;
            if (mispredict) stat_mispred <= stat_mispred + 32'd1;
`ifdef SIMULATION
            if (pred_valid) stats_event("vp_pred");
            if (confirm)    stats_event("vp_correct");
            if (mispredict) stats_event("vp_mispred");
`endif
        end
    end
`endif

endmodule

// File: tb/tb_load_value_predictor.sv
// Scoreboard bench for load_value_predictor: expected pulses are queued at stimulus time
// and popped by an independent monitor whenever pred_valid/confirm/mispredict fire.
module tb_load_value_predictor;

    localparam int EV_PRED = 0;
    localparam int EV_CONF = 1;
    localparam int EV_MISP = 2;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        req_ready;
    logic        pred_valid;
    logic [31:0] pred_value;
    logic        busy;
    logic        resolve_valid;
    logic [31:0] resolve_data;
    logic        flush;
    logic        confirm;
    logic        mispredict;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    load_value_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_pc        (req_pc),
        .req_ready     (req_ready),
        .pred_valid    (pred_valid),
        .pred_value    (pred_value),
        .busy          (busy),
        .resolve_valid (resolve_valid),
        .resolve_data  (resolve_data),
        .flush         (flush),
        .confirm       (confirm),
        .mispredict    (mispredict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input logic [31:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got kind %0d value 0x%0h, expected none", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                errors++;
                $display("FAIL pulse: got kind %0d value 0x%0h, expected kind %0d value 0x%0h",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    // Monitor: sampled on the falling edge, independent of stimulus
    always @(negedge clk) begin
        if (confirm === 1'b1 && mispredict === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL exclusive: confirm and mispredict both 1, expected at most one");
        end
        if (pred_valid === 1'b1) pop_cmp(EV_PRED, pred_value);
        if (confirm === 1'b1)    pop_cmp(EV_CONF, 32'h0);
        if (mispredict === 1'b1) pop_cmp(EV_MISP, 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && req_ready !== 1'b1; i++) tick();
        if (req_ready !== 1'b1) chk("wait_ready_timeout", {31'b0, req_ready}, 32'h1);
    endtask

    // exp_kind: 0 = no prediction, 1 = predict+confirm, 2 = predict+mispredict
    task automatic do_load(input logic [31:0] pc, input logic [31:0] data,
                           input int exp_kind, input logic [31:0] exp_val, input int lat);
        wait_ready();
        req_valid = 1'b1;
        req_pc    = pc;
        if (exp_kind != 0) push(EV_PRED, exp_val);
        tick();
        req_valid = 1'b0;
        repeat (lat) tick();
        resolve_valid = 1'b1;
        resolve_data  = data;
        if (exp_kind == 1) push(EV_CONF, 32'h0);
        if (exp_kind == 2) push(EV_MISP, 32'h0);
        tick();
        resolve_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_pc        = '0;
        resolve_valid = 1'b0;
        resolve_data  = '0;
        flush         = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("reset_req_ready",  {31'b0, req_ready},  32'h1);
        chk("reset_busy",       {31'b0, busy},       32'h0);
        chk("reset_pred_valid", {31'b0, pred_valid}, 32'h0);
        chk("reset_pred_value", pred_value,          32'h0);
        chk("reset_confirm",    {31'b0, confirm},    32'h0);
        chk("reset_mispredict", {31'b0, mispredict}, 32'h0);

        // Cold train then confidence build 0 -> 1 -> 2 -> predict
        do_load(32'h100, 32'hAAAA, 0, 32'h0, 0);
        do_load(32'h100, 32'hAAAA, 0, 32'h0, 1);
        do_load(32'h100, 32'hAAAA, 0, 32'h0, 0);
        do_load(32'h100, 32'hAAAA, 1, 32'hAAAA, 2);
        // Saturation: confidence stays at max
        for (int r = 0; r < 5; r++) do_load(32'h100, 32'hAAAA, 1, 32'hAAAA, r % 3);

        // Mispredict, then the stored value is 0xBBBB with conf reset to 0
        do_load(32'h100, 32'hBBBB, 2, 32'hAAAA, 1);
        do_load(32'h100, 32'hBBBB, 0, 32'h0, 0);
        do_load(32'h100, 32'hBBBB, 0, 32'h0, 0);
        do_load(32'h100, 32'hBBBB, 1, 32'hBBBB, 0);

        // Alias at index 0: 0x200 evicts 0x100, which then misses
        do_load(32'h200, 32'hCCCC, 0, 32'h0, 0);
        do_load(32'h100, 32'hBBBB, 0, 32'h0, 0);

        // Backpressure with a held request to an index trained to conf=1
        do_load(32'h180, 32'h1234, 0, 32'h0, 0);
        do_load(32'h180, 32'h1234, 0, 32'h0, 0);
        wait_ready();
        req_valid = 1'b1;
        req_pc    = 32'h180;
        tick();
        chk("bp_ready_wait0", {31'b0, req_ready}, 32'h0);
        chk("bp_busy_wait0",  {31'b0, busy},      32'h1);
        tick();
        chk("bp_ready_wait1", {31'b0, req_ready}, 32'h0);
        resolve_valid = 1'b1;
        resolve_data  = 32'h1234;
        push(EV_PRED, 32'h1234);
        tick();
        resolve_valid = 1'b0;
        chk("bp_ready_after_resolve", {31'b0, req_ready}, 32'h1);
        tick();
        req_valid = 1'b0;
        chk("bp_second_accepted", {31'b0, busy}, 32'h1);
        resolve_valid = 1'b1;
        resolve_data  = 32'h1234;
        push(EV_CONF, 32'h0);
        tick();
        resolve_valid = 1'b0;

        // Flush together with resolve: no pulse, no training
        wait_ready();
        req_valid = 1'b1;
        req_pc    = 32'h180;
        push(EV_PRED, 32'h1234);
        tick();
        req_valid     = 1'b0;
        resolve_valid = 1'b1;
        resolve_data  = 32'h5555;
        flush         = 1'b1;
        tick();
        resolve_valid = 1'b0;
        flush         = 1'b0;
        chk("flush_idle_ready", {31'b0, req_ready}, 32'h1);
        chk("flush_idle_busy",  {31'b0, busy},      32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_in_idle_ready", {31'b0, req_ready}, 32'h1);
        do_load(32'h180, 32'h1234, 1, 32'h1234, 0);

        // Reset during WAIT clears the table
        wait_ready();
        req_valid = 1'b1;
        req_pc    = 32'h180;
        push(EV_PRED, 32'h1234);
        tick();
        req_valid = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_wait_ready",      {31'b0, req_ready},  32'h1);
        chk("rst_wait_busy",       {31'b0, busy},       32'h0);
        chk("rst_wait_pred_valid", {31'b0, pred_valid}, 32'h0);
        chk("rst_wait_confirm",    {31'b0, confirm},    32'h0);
        chk("rst_wait_mispredict", {31'b0, mispredict}, 32'h0);
        do_load(32'h180, 32'h1234, 0, 32'h0, 0);

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_value_predictor.md
Name: load_value_predictor

Overview:
- Last-value load predictor that sits directly upstream of the hazard controller and feeds it the predicted load value.
- When EX issues a load, the block looks up a direct-mapped table indexed by load PC. On a confident hit it returns the last value seen for that PC.
- It then waits for the real D-cache data, flags confirm or mispredict to the hazard controller (which drives snapshot recovery), and trains the table.
- Only one prediction is outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, load PC width.
- DATA_WIDTH, 32, load data width.
- INDEX_BITS, 6, table has 2^INDEX_BITS entries.
- CONF_BITS, 2, saturating confidence counter width.
- CONF_THRESH, 2, minimum confidence required to emit a prediction.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  load lookup request from EX
- req_pc  in  ADDR_WIDTH  PC of the load
- req_ready  out  1  high when IDLE; a request is accepted only when req_valid && req_ready
- pred_valid  out  1  one-cycle pulse: confident prediction available
- pred_value  out  DATA_WIDTH  predicted load data; meaningful only while pred_valid is high
- busy  out  1  a prediction or training is outstanding (lock)
- resolve_valid  in  1  actual load data has returned from the D-cache
- resolve_data  in  DATA_WIDTH  actual load data
- flush  in  1  cancel the outstanding request
- confirm  out  1  one-cycle pulse: prediction matched the actual data
- mispredict  out  1  one-cycle pulse: prediction did not match; hazard controller starts recovery

Behaviour:
- Table fields:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[ADDR_WIDTH-1:INDEX_BITS+2]
  - each entry holds valid, tag, value, conf.
- Reset, applied at the next clk edge:
  - state IDLE; every entry valid=0, conf=0
  - pred_valid, confirm, mispredict, busy = 0; pred_value = 0; req_ready = 1
  - reset mid-WAIT discards the outstanding request with no pulses and no table write.
- States:
  - IDLE: req_ready=1, busy=0; resolve_valid is ignored.
  - WAIT: req_ready=0, busy=1.
- IDLE -> WAIT on request accept at cycle N:
  - latch pc, index and tag
  - hit = valid && tag match; predicted = hit && conf >= CONF_THRESH.
- Cycle N+1 (first WAIT cycle):
  - pred_valid = predicted, for exactly one cycle
  - pred_value = entry value; 0 when not predicted.
- WAIT, resolve_valid at cycle M >= N+1 (M = N+1 allowed), with no flush:
  - cycle M+1: confirm = predicted && (resolve_data == pred_value); mispredict = predicted && (resolve_data != pred_value).
  - table write at the M edge, visible to lookups from M+1:
    - hit and equal: conf saturating +1; conf never wraps past 2^CONF_BITS-1.
    - hit and different: value <= resolve_data, conf <= 0.
    - miss: valid <= 1, tag, value <= resolve_data, conf <= 0. This evicts any aliasing entry.
  - state returns to IDLE at M+1, so a new request can be accepted at M+1.
  - a request at M+1 to the same index sees the updated entry.
- WAIT with flush:
  - state returns to IDLE; no table write, no confirm/mispredict pulse.
  - flush and resolve_valid in the same cycle: flush wins.
  - flush in IDLE has no effect.
- req_valid while busy is not accepted; the requester holds the request until req_ready.
- confirm and mispredict are never high together and never high outside the cycle after a resolve.

Optional Feature:
- Macro: LOAD_VALUE_PREDICTOR_STATS_EN.
- With the macro defined, three extra outputs stat_pred, stat_correct, stat_mispred (each 32 bits):
  - they count pred_valid, confirm and mispredict pulses
  - cleared by rst, wrap modulo 2^32
  - in SIMULATION builds, each pulse also calls stats_event("vp_pred"), stats_event("vp_correct") or stats_event("vp_mispred").
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold train: after reset, req pc=0x100, resolve 0xAAAA -> pred_valid=0, no confirm or mispredict; entry 0x100 valid with conf=0.
- Confidence build (CONF_THRESH=2):
  - 3 more rounds at pc=0x100, each resolving 0xAAAA; pred_valid=0 on rounds 1 and 2 (conf goes 0->1->2).
  - on round 3, pred_valid=1 with pred_value=0xAAAA, then confirm=1.
  - 5 further correct rounds -> conf stays at 3.
- Mispredict: trained entry (conf=3, value 0xAAAA), resolve 0xBBBB -> mispredict=1 at M+1; next lookup of 0x100 gives pred_valid=0 and stored value 0xBBBB.
- Alias / backpressure:
  - pc=0x100 trained, then req pc=0x200 (same index with INDEX_BITS=6) -> miss, no prediction, entry replaced by the new tag.
  - req_valid held during WAIT -> req_ready=0 until the cycle after resolve, then the request is accepted.
- Flush / reset:
  - flush together with resolve_valid -> no pulses, table unchanged, IDLE next cycle.
  - rst during WAIT -> all outputs 0, busy=0; the previously trained pc no longer hits.
